// File: rtl/regfile_wb_sched.sv
`default_nettype none
// ============================================================================
// Module   : regfile_wb_sched
// Purpose  : Write-back scheduler and scoreboard for the 32x64 register file.
//            Arbitrates the single register-file write port between the
//            ALU/execute path (requester 0) and the load/memory path
//            (requester 1), and tracks destination registers that still have
//            a write outstanding so decode can stall on RAW/WAW hazards.
//
// Ports    : Clk, Reset_n         - clock (rising edge), async active-low reset
//            Flush                - pipeline flush, clears the scoreboard
//            AllocValid/AllocRd   - decode destination allocation request
//            AllocReady           - allocation accepted this cycle (comb)
//            QueryRA/QueryRB      - decode source indices
//            BusyA/BusyB          - source has a pending write (comb)
//            Wr0*/Wr1*            - writeback requests (valid, rd, data)
//            Wr0Ready/Wr1Ready    - request granted this cycle (comb)
//            RegWr/RW/BusW        - registered register-file write port
//            Err                  - sticky: write accepted to a non-pending reg
//
// Revision : 1.0 - initial release
// ============================================================================
module regfile_wb_sched #(
  parameter int DATA_W   = 64,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 31
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              Flush,
  // Allocation from decode
  input  logic              AllocValid,
  input  logic [ADDR_W-1:0] AllocRd,
  output logic              AllocReady,
  // Hazard query from decode
  input  logic [ADDR_W-1:0] QueryRA,
  input  logic [ADDR_W-1:0] QueryRB,
  output logic              BusyA,
  output logic              BusyB,
  // Writeback requester 0 (ALU / execute)
  input  logic              Wr0Valid,
  input  logic [ADDR_W-1:0] Wr0Rd,
  input  logic [DATA_W-1:0] Wr0Data,
  output logic              Wr0Ready,
  // Writeback requester 1 (load / memory)
  input  logic              Wr1Valid,
  input  logic [ADDR_W-1:0] Wr1Rd,
  input  logic [DATA_W-1:0] Wr1Data,
  output logic              Wr1Ready,
  // Register file write port
  output logic              RegWr,
  output logic [ADDR_W-1:0] RW,
  output logic [DATA_W-1:0] BusW,
  // Status
  output logic              Err
);

  localparam int                c_nregs    = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] c_zero_idx = ADDR_W'(ZERO_REG);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [c_nregs-1:0] r_busy;
  // Last requester granted: 0 = requester 0, 1 = requester 1.
  // Reset value 1 so that requester 0 wins the first contention.
  logic               r_last_gnt;
  logic               r_regwr;
  logic [ADDR_W-1:0]  r_rw;
  logic [DATA_W-1:0]  r_busw;
  logic               r_err;

  // --------------------------------------------------------------------------
  // Combinational
  // --------------------------------------------------------------------------
  logic               w_alloc_is_zero;
  logic               w_alloc_ready;
  logic               w_alloc_set;
  logic               w_gnt0;
  logic               w_gnt1;
  logic               w_gnt_any;
  logic [ADDR_W-1:0]  w_sel_rd;
  logic [DATA_W-1:0]  w_sel_data;
  logic               w_sel_is_zero;
  logic               w_err_set;
  logic [c_nregs-1:0] w_busy_nxt;

  // Scoreboard lookups. r_busy[c_zero_idx] is held at 0, so a query of the
  // zero register never reports busy.
  assign BusyA = r_busy[QueryRA];
  assign BusyB = r_busy[QueryRB];

  // Allocation: the zero register is always accepted but never tracked.
  // A register that is still busy is rejected even if its write completes
  // this very cycle; the busy bit is sampled before the clear takes effect.
  assign w_alloc_is_zero = (AllocRd == c_zero_idx);
  assign w_alloc_ready   = AllocValid & ~Flush & (w_alloc_is_zero | ~r_busy[AllocRd]);
  assign w_alloc_set     = w_alloc_ready & ~w_alloc_is_zero;
  assign AllocReady      = w_alloc_ready;

  // Round-robin arbitration. Grants depend only on the valid bits, the
  // pointer and Flush -- never on request data or destination.
  assign w_gnt0    = ~Flush & Wr0Valid & (~Wr1Valid |  r_last_gnt);
  assign w_gnt1    = ~Flush & Wr1Valid & (~Wr0Valid | ~r_last_gnt);
  assign w_gnt_any = w_gnt0 | w_gnt1;

  assign Wr0Ready = w_gnt0;
  assign Wr1Ready = w_gnt1;

  // Granted request payload
  assign w_sel_rd      = w_gnt1 ? Wr1Rd   : Wr0Rd;
  assign w_sel_data    = w_gnt1 ? Wr1Data : Wr0Data;
  assign w_sel_is_zero = (w_sel_rd == c_zero_idx);

  // A non-zero destination that was never allocated indicates a pipeline bug.
  assign w_err_set = w_gnt_any & ~w_sel_is_zero & ~r_busy[w_sel_rd];

  // Next scoreboard value. The write-stage clear and the allocation set are
  // applied independently so different registers both take effect on the
  // same edge. If the same register appears in both (only possible when the
  // write was to a non-pending register), the new allocation wins so the
  // fresh hazard is not lost.
  always_comb begin
    w_busy_nxt = r_busy;
    if (Flush) begin
      w_busy_nxt = '0;
    end else begin
      if (r_regwr) begin
        w_busy_nxt[r_rw] = 1'b0;
      end
      if (w_alloc_set) begin
        w_busy_nxt[AllocRd] = 1'b1;
      end
    end
    w_busy_nxt[c_zero_idx] = 1'b0;
  end

  // --------------------------------------------------------------------------
  // Sequential
  // --------------------------------------------------------------------------
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_nxt;
    end
  end

  // Pointer moves only when someone is actually granted.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_last_gnt <= 1'b1;
    end else if (w_gnt_any) begin
      r_last_gnt <= w_gnt1;
    end
  end

  // Write stage: one cycle after the grant. A grant to the zero register is
  // consumed here but produces no register-file write. RW/BusW hold when
  // nothing is granted.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_regwr <= 1'b0;
      r_rw    <= '0;
      r_busw  <= '0;
    end else begin
      r_regwr <= w_gnt_any & ~w_sel_is_zero;
      if (w_gnt_any) begin
        r_rw   <= w_sel_rd;
        r_busw <= w_sel_data;
      end
    end
  end

  // Sticky error, cleared only by reset.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_err <= 1'b0;
    end else if (w_err_set) begin
      r_err <= 1'b1;
    end
  end

  assign RegWr = r_regwr;
  assign RW    = r_rw;
  assign BusW  = r_busw;
  assign Err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_wb_sched
// Purpose  : Directed self-checking bench for regfile_wb_sched.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_regfile_wb_sched;

  localparam int DATA_W = 64;
  localparam int ADDR_W = 5;

  logic              Clk;
  logic              Reset_n;
  logic              Flush;
  logic              AllocValid;
  logic [ADDR_W-1:0] AllocRd;
  logic              AllocReady;
  logic [ADDR_W-1:0] QueryRA;
  logic [ADDR_W-1:0] QueryRB;
  logic              BusyA;
  logic              BusyB;
  logic              Wr0Valid;
  logic [ADDR_W-1:0] Wr0Rd;
  logic [DATA_W-1:0] Wr0Data;
  logic              Wr0Ready;
  logic              Wr1Valid;
  logic [ADDR_W-1:0] Wr1Rd;
  logic [DATA_W-1:0] Wr1Data;
  logic              Wr1Ready;
  logic              RegWr;
  logic [ADDR_W-1:0] RW;
  logic [DATA_W-1:0] BusW;
  logic              Err;

  int n_checks;
  int n_fails;

  regfile_wb_sched #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .ZERO_REG (31)
  ) u_dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .Flush      (Flush),
    .AllocValid (AllocValid),
    .AllocRd    (AllocRd),
    .AllocReady (AllocReady),
    .QueryRA    (QueryRA),
    .QueryRB    (QueryRB),
    .BusyA      (BusyA),
    .BusyB      (BusyB),
    .Wr0Valid   (Wr0Valid),
    .Wr0Rd      (Wr0Rd),
    .Wr0Data    (Wr0Data),
    .Wr0Ready   (Wr0Ready),
    .Wr1Valid   (Wr1Valid),
    .Wr1Rd      (Wr1Rd),
    .Wr1Data    (Wr1Data),
    .Wr1Ready   (Wr1Ready),
    .RegWr      (RegWr),
    .RW         (RW),
    .BusW       (BusW),
    .Err        (Err)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Single-cycle allocation of one register.
  task automatic alloc(input logic [ADDR_W-1:0] rd);
    AllocValid = 1'b1;
    AllocRd    = rd;
    tick();
    AllocValid = 1'b0;
  endtask

  initial begin
    n_checks   = 0;
    n_fails    = 0;
    Reset_n    = 1'b0;
    Flush      = 1'b0;
    AllocValid = 1'b0;
    AllocRd    = '0;
    QueryRA    = 5'd5;
    QueryRB    = 5'd0;
    Wr0Valid   = 1'b0;
    Wr0Rd      = '0;
    Wr0Data    = '0;
    Wr1Valid   = 1'b0;
    Wr1Rd      = '0;
    Wr1Data    = '0;

    // ---------------- Reset state ----------------
    tick();
    tick();
    chk("rst_regwr", 64'(RegWr), 64'd0);
    chk("rst_rw",    64'(RW),    64'd0);
    chk("rst_busw",  BusW,       64'd0);
    chk("rst_err",   64'(Err),   64'd0);
    chk("rst_busyA", 64'(BusyA), 64'd0);
    Reset_n = 1'b1;
    tick();

    // ---------------- Allocate X5 ----------------
    AllocValid = 1'b1;
    AllocRd    = 5'd5;
    #1;
    chk("alloc5_ready", 64'(AllocReady), 64'd1);
    tick();
    AllocValid = 1'b0;
    #1;
    chk("alloc5_busy", 64'(BusyA), 64'd1);

    // ---------------- Wr0 X5 <= 0xDEAD ----------------
    Wr0Valid = 1'b1;
    Wr0Rd    = 5'd5;
    Wr0Data  = 64'hDEAD;
    #1;
    chk("wr5_ready0", 64'(Wr0Ready), 64'd1);
    chk("wr5_ready1", 64'(Wr1Ready), 64'd0);
    tick();
    Wr0Valid = 1'b0;
    chk("wr5_regwr", 64'(RegWr), 64'd1);
    chk("wr5_rw",    64'(RW),    64'd5);
    chk("wr5_busw",  BusW,       64'hDEAD);
    chk("wr5_busy_during", 64'(BusyA), 64'd1);
    tick();
    chk("wr5_regwr_off", 64'(RegWr), 64'd0);
    chk("wr5_busy_clr",  64'(BusyA), 64'd0);

    // ---------------- Zero register: alloc + Wr1 ----------------
    // Wr1 grant here also makes requester 1 the most recent winner.
    QueryRB    = 5'd31;
    AllocValid = 1'b1;
    AllocRd    = 5'd31;
    Wr1Valid   = 1'b1;
    Wr1Rd      = 5'd31;
    Wr1Data    = 64'h55;
    #1;
    chk("x31_alloc_ready", 64'(AllocReady), 64'd1);
    chk("x31_wr1_ready",   64'(Wr1Ready),   64'd1);
    tick();
    AllocValid = 1'b0;
    Wr1Valid   = 1'b0;
    chk("x31_regwr", 64'(RegWr), 64'd0);
    chk("x31_busy",  64'(BusyB), 64'd0);
    chk("x31_err",   64'(Err),   64'd0);

    // ---------------- Contention X3 / X4 ----------------
    alloc(5'd3);
    alloc(5'd4);
    QueryRA  = 5'd3;
    QueryRB  = 5'd4;
    Wr0Valid = 1'b1; Wr0Rd = 5'd3; Wr0Data = 64'h11;
    Wr1Valid = 1'b1; Wr1Rd = 5'd4; Wr1Data = 64'h22;
    #1;
    chk("rr1_busyA", 64'(BusyA), 64'd1);
    chk("rr1_busyB", 64'(BusyB), 64'd1);
    chk("rr1_gnt0",  64'(Wr0Ready), 64'd1);
    chk("rr1_gnt1",  64'(Wr1Ready), 64'd0);
    tick();
    chk("rr2_gnt0",  64'(Wr0Ready), 64'd0);
    chk("rr2_gnt1",  64'(Wr1Ready), 64'd1);
    chk("rr2_regwr", 64'(RegWr), 64'd1);
    chk("rr2_rw",    64'(RW),    64'd3);
    chk("rr2_busw",  BusW,       64'h11);
    tick();
    Wr0Valid = 1'b0;
    Wr1Valid = 1'b0;
    chk("rr3_regwr", 64'(RegWr), 64'd1);
    chk("rr3_rw",    64'(RW),    64'd4);
    chk("rr3_busw",  BusW,       64'h22);
    tick();
    chk("rr4_busyA", 64'(BusyA), 64'd0);
    chk("rr4_busyB", 64'(BusyB), 64'd0);

    // ---------------- WAW on X7, pointer alternation ----------------
    alloc(5'd7);
    AllocValid = 1'b1;
    AllocRd    = 5'd7;
    #1;
    chk("waw7_ready", 64'(AllocReady), 64'd0);
    AllocValid = 1'b0;
    // Requester 1 won last, so requester 0 wins this contention.
    Wr0Valid = 1'b1; Wr0Rd = 5'd7; Wr0Data = 64'h77;
    Wr1Valid = 1'b1; Wr1Rd = 5'd8; Wr1Data = 64'h88;
    #1;
    chk("rr5_gnt0", 64'(Wr0Ready), 64'd1);
    chk("rr5_gnt1", 64'(Wr1Ready), 64'd0);
    tick();
    Wr0Valid = 1'b0;
    Wr1Valid = 1'b0;
    // X7 write is in the write stage; re-alloc is still rejected.
    QueryRA    = 5'd7;
    AllocValid = 1'b1;
    AllocRd    = 5'd7;
    #1;
    chk("x7_wstage_rw", 64'(RW), 64'd7);
    chk("x7_clr_alloc_ready", 64'(AllocReady), 64'd0);
    tick();
    AllocValid = 1'b0;
    chk("x7_busy_clr", 64'(BusyA), 64'd0);
    chk("x7_err",      64'(Err),   64'd0);

    // ---------------- Flush ----------------
    alloc(5'd2);
    alloc(5'd9);
    QueryRA    = 5'd2;
    QueryRB    = 5'd9;
    Flush      = 1'b1;
    Wr0Valid   = 1'b1; Wr0Rd = 5'd2; Wr0Data = 64'h22;
    AllocValid = 1'b1; AllocRd = 5'd10;
    #1;
    chk("fl_wr0_ready",   64'(Wr0Ready),   64'd0);
    chk("fl_alloc_ready", 64'(AllocReady), 64'd0);
    chk("fl_busyA_pre",   64'(BusyA),      64'd1);
    chk("fl_busyB_pre",   64'(BusyB),      64'd1);
    tick();
    Flush      = 1'b0;
    Wr0Valid   = 1'b0;
    AllocValid = 1'b0;
    chk("fl_busyA", 64'(BusyA), 64'd0);
    chk("fl_busyB", 64'(BusyB), 64'd0);
    chk("fl_regwr", 64'(RegWr), 64'd0);

    // ---------------- Err on non-pending X12 ----------------
    Wr0Valid = 1'b1; Wr0Rd = 5'd12; Wr0Data = 64'h12;
    #1;
    chk("err_wr0_ready", 64'(Wr0Ready), 64'd1);
    tick();
    Wr0Valid = 1'b0;
    chk("err_set",   64'(Err),   64'd1);
    chk("err_regwr", 64'(RegWr), 64'd1);
    tick();
    tick();
    chk("err_sticky", 64'(Err), 64'd1);

    // ---------------- Async reset mid-write ----------------
    alloc(5'd13);
    QueryRA  = 5'd13;
    Wr0Valid = 1'b1; Wr0Rd = 5'd13; Wr0Data = 64'h1313;
    tick();
    Wr0Valid = 1'b0;
    chk("rw13_regwr", 64'(RegWr), 64'd1);
    chk("rw13_busy",  64'(BusyA), 64'd1);
    Reset_n = 1'b0;
    #1;
    chk("arst_regwr", 64'(RegWr), 64'd0);
    chk("arst_err",   64'(Err),   64'd0);
    chk("arst_busy",  64'(BusyA), 64'd0);
    chk("arst_rw",    64'(RW),    64'd0);
    chk("arst_busw",  BusW,       64'd0);
    tick();
    Reset_n = 1'b1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/regfile_wb_sched.md
Name: regfile_wb_sched

Overview:
- Write-back scheduler and scoreboard for the 32x64 register file (X31 reads as zero, writes to X31 ignored).
- Shares the register file's single write port between two writeback requesters: requester 0 is the ALU/execute path, requester 1 is the load/memory path.
- Tracks destination registers with writes still pending, so decode can stall on RAW/WAW hazards.
- Drives the register file's RegWr/RW/BusW write port from registered outputs.

Parameters:
- DATA_W, 64, writeback data width.
- ADDR_W, 5, register index width.
- ZERO_REG, 31, hard-wired zero register index; never tracked, never written.

Ports:
- Clk  in  1  clock, rising edge.
- Reset_n  in  1  asynchronous active-low reset.
- Flush  in  1  pipeline flush; clears scoreboard.
- AllocValid  in  1  decode issues an instruction with destination AllocRd.
- AllocRd  in  ADDR_W  destination register to mark pending.
- AllocReady  out  1  allocation accepted this cycle (combinational).
- QueryRA, QueryRB  in  ADDR_W each  decode source indices.
- BusyA, BusyB  out  1 each  source has a pending write (combinational).
- Wr0Valid, Wr1Valid  in  1 each  writeback request.
- Wr0Rd, Wr1Rd  in  ADDR_W each  writeback destination.
- Wr0Data, Wr1Data  in  DATA_W each  writeback data.
- Wr0Ready, Wr1Ready  out  1 each  request granted this cycle (combinational).
- RegWr  out  1  register file write enable (registered).
- RW  out  ADDR_W  register file write index (registered).
- BusW  out  DATA_W  register file write data (registered).
- Err  out  1  sticky: a write was accepted to a non-pending register.

Behaviour:
- Reset (async, Reset_n=0):
  - RegWr=0, RW=0, BusW=0, Err=0.
  - All busy bits cleared.
  - Round-robin pointer set so requester 0 wins first contention.
- Scoreboard: 32-bit busy vector.
  - Busy[ZERO_REG] is always 0.
  - BusyA = busy[QueryRA]; BusyB = busy[QueryRB].
- Allocation:
  - AllocReady = AllocValid & ~Flush & (AllocRd==ZERO_REG | ~busy[AllocRd]).
  - On AllocReady, busy[AllocRd] is set at the next edge; no bit is set for ZERO_REG.
  - Allocating a register that is still busy is rejected (WAW stall), even if it clears in the same cycle.
- Arbitration:
  - Flush=1 forces both Wr*Ready=0.
  - Only one requester valid: it is granted.
  - Both valid: round-robin. Grant the requester not granted most recently; the pointer updates only on a grant.
  - At most one WrNReady is high per cycle. Ready never depends on the other requester's data.
- Write stage, one cycle latency:
  - A grant in cycle N drives RegWr=1, RW=WrNRd, BusW=WrNData in cycle N+1.
  - If WrNRd==ZERO_REG, the request is still accepted but RegWr=0 in N+1.
  - No grant in cycle N: RegWr=0 in N+1. RW/BusW hold their previous values.
- Busy clear:
  - busy[RW] clears at the edge ending a cycle with RegWr=1, i.e. the same edge the register file captures BusW.
  - BusyX therefore drops only once the register file holds the new value.
  - Allocation of the same register in that cycle is still rejected, per the rule above.
- Err: set at the grant edge if WrNRd != ZERO_REG and busy[WrNRd]=0. Cleared only by reset.
- Flush:
  - Clears all busy bits at the next edge.
  - Does not cancel a write already in the write stage (RegWr in the flush cycle still completes).
- Clear and set of different registers in the same edge both take effect.

Test Plan:
- Reset, then alloc X5 -> AllocReady=1; next cycle BusyA=1 with QueryRA=5.
- Wr0 on X5 with 0xDEAD -> Wr0Ready=1; next cycle RegWr=1, RW=5, BusW=0xDEAD; BusyA=0 the cycle after.
- Alloc X3 and X4; Wr0(X3,0x11) and Wr1(X4,0x22) valid together for 2 cycles:
  - Grants are r0 then r1.
  - RegWr writes X3=0x11, then X4=0x22 on consecutive cycles.
  - The pointer alternates on the next contention.
- Alloc X7 while X7 busy -> AllocReady=0. Alloc X31 -> AllocReady=1, busy unchanged. Wr1 to X31 -> accepted, RegWr=0.
- Flush with X2, X9 busy and Wr0 valid -> Wr0Ready=0, AllocReady=0; next cycle BusyA/BusyB=0 for X2/X9.
- Wr0 to non-busy X12 -> Err=1 and stays 1. Assert Reset_n=0 mid-write -> RegWr, Err, and busy bits clear immediately.
